pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register; successor to the fixed-width EX/MEM latch.
- Carries a PC/instruction bus and a stage-to-stage payload bus between any two adjacent pipeline stages (ID/EX, EX/MEM, MEM/WB).
- Adds valid/allowin handshaking, flush, and an optional 2-entry skid mode that registers the upstream allowin path.
- Adds a saturating stall counter for performance debug.

---
 rtl/pipe_stage_reg.sv | 116 +++++++++++
 tb/tb_pipe_stage_reg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_reg
// Brief   : Parametrised inter-stage pipeline register with valid/allowin
//           handshake, flush, optional 2-entry skid buffer, stall counter.
// Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int BUS_W     = 64,
    parameter int PC_INST_W = 64,
    parameter int SKID_EN   = 0,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_allowin_o,
    input  logic [PC_INST_W-1:0] pc_inst_ibus,
    input  logic [BUS_W-1:0]     to_ibus,
    output logic                 out_valid_o,
    input  logic                 out_allowin_i,
    output logic [PC_INST_W-1:0] pc_inst_obus,
    output logic [BUS_W-1:0]     to_obus,
    output logic [CNT_W-1:0]     stall_cnt_o
);

    logic                 head_valid;
    logic [PC_INST_W-1:0] head_pc;
    logic [BUS_W-1:0]     head_bus;
    logic [CNT_W-1:0]     stall_cnt;
    logic                 in_xfer;
    logic                 out_xfer;

    // A flush in the same cycle discards the incoming entry.
    assign in_xfer  = in_valid_i && in_allowin_o && !flush_i;
    assign out_xfer = head_valid && out_allowin_i;

    generate
        if (SKID_EN == 0) begin : g_single
            assign in_allowin_o = !head_valid || out_allowin_i;

            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    head_valid <= 1'b0;
                    head_pc    <= '0;
                    head_bus   <= '0;
                end else if (flush_i) begin
                    head_valid <= 1'b0;
                end else if (in_xfer) begin
                    head_valid <= 1'b1;
                    head_pc    <= pc_inst_ibus;
                    head_bus   <= to_ibus;
                end else if (out_xfer) begin
                    head_valid <= 1'b0;
                end
            end
        end else begin : g_skid
            logic                 skid_valid;
            logic                 allowin_q;
            logic [PC_INST_W-1:0] skid_pc;
            logic [BUS_W-1:0]     skid_bus;

            assign in_allowin_o = allowin_q;

            // allowin_q mirrors !skid_valid, so an input can never land while
            // the skid entry is occupied.
            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    head_valid <= 1'b0;
                    head_pc    <= '0;
                    head_bus   <= '0;
                    skid_valid <= 1'b0;
                    skid_pc    <= '0;
                    skid_bus   <= '0;
                    allowin_q  <= 1'b1;
                end else if (flush_i) begin
                    head_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    allowin_q  <= 1'b1;
                end else if (out_xfer && skid_valid) begin
                    head_pc    <= skid_pc;
                    head_bus   <= skid_bus;
                    skid_valid <= 1'b0;
                    allowin_q  <= 1'b1;
                end else if (in_xfer && (!head_valid || out_xfer)) begin
                    head_valid <= 1'b1;
                    head_pc    <= pc_inst_ibus;
                    head_bus   <= to_ibus;
                end else if (in_xfer) begin
                    skid_valid <= 1'b1;
                    skid_pc    <= pc_inst_ibus;
                    skid_bus   <= to_ibus;
                    allowin_q  <= 1'b0;
                end else if (out_xfer) begin
                    head_valid <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stall_cnt <= '0;
        end else if (head_valid && !out_allowin_i && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid_o  = head_valid;
    assign pc_inst_obus = head_pc;
    assign to_obus      = head_bus;
    assign stall_cnt_o  = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_stage_reg
// Brief   : Directed self-checking bench for pipe_stage_reg (three configs).
// Rev     : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    // A: SKID_EN=0, 64/64, CNT_W=16
    logic        a_flush, a_in_valid, a_in_allowin, a_out_valid, a_out_allowin;
    logic [63:0] a_pc_in, a_bus_in, a_pc_out, a_bus_out;
    logic [15:0] a_stall;
    // B: SKID_EN=1, 64/64, CNT_W=3
    logic        b_flush, b_in_valid, b_in_allowin, b_out_valid, b_out_allowin;
    logic [63:0] b_pc_in, b_bus_in, b_pc_out, b_bus_out;
    logic [2:0]  b_stall;
    // C: SKID_EN=1, BUS_W=1, PC_INST_W=96
    logic        c_flush, c_in_valid, c_in_allowin, c_out_valid, c_out_allowin;
    logic [95:0] c_pc_in, c_pc_out;
    logic [0:0]  c_bus_in, c_bus_out;
    logic [15:0] c_stall;

    pipe_stage_reg #(.BUS_W(64), .PC_INST_W(64), .SKID_EN(0), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst), .flush_i(a_flush), .in_valid_i(a_in_valid),
        .in_allowin_o(a_in_allowin), .pc_inst_ibus(a_pc_in), .to_ibus(a_bus_in),
        .out_valid_o(a_out_valid), .out_allowin_i(a_out_allowin),
        .pc_inst_obus(a_pc_out), .to_obus(a_bus_out), .stall_cnt_o(a_stall));

    pipe_stage_reg #(.BUS_W(64), .PC_INST_W(64), .SKID_EN(1), .CNT_W(3)) u_b (
        .clk(clk), .rst_n(rst), .flush_i(b_flush), .in_valid_i(b_in_valid),
        .in_allowin_o(b_in_allowin), .pc_inst_ibus(b_pc_in), .to_ibus(b_bus_in),
        .out_valid_o(b_out_valid), .out_allowin_i(b_out_allowin),
        .pc_inst_obus(b_pc_out), .to_obus(b_bus_out), .stall_cnt_o(b_stall));

    pipe_stage_reg #(.BUS_W(1), .PC_INST_W(96), .SKID_EN(1), .CNT_W(16)) u_c (
        .clk(clk), .rst_n(rst), .flush_i(c_flush), .in_valid_i(c_in_valid),
        .in_allowin_o(c_in_allowin), .pc_inst_ibus(c_pc_in), .to_ibus(c_bus_in),
        .out_valid_o(c_out_valid), .out_allowin_i(c_out_allowin),
        .pc_inst_obus(c_pc_out), .to_obus(c_bus_out), .stall_cnt_o(c_stall));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid got %b exp 0", a_out_valid); end
        n_cmp++; if (a_in_allowin !== 1'b1) begin n_err++; $display("FAIL rst_a_allowin got %b exp 1", a_in_allowin); end
        n_cmp++; if (b_in_allowin !== 1'b1) begin n_err++; $display("FAIL rst_b_allowin got %b exp 1", b_in_allowin); end
        n_cmp++; if (b_pc_out !== 64'h0) begin n_err++; $display("FAIL rst_b_pc got %h exp 0", b_pc_out); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (b_in_allowin !== 1'b1) begin n_err++; $display("FAIL rel_b_allowin got %b exp 1", b_in_allowin); end
        a_out_allowin = 1'b0; a_in_valid = 1'b1; a_pc_in = 64'h1234; a_bus_in = 64'hBEEF;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_cmp++; if (a_pc_out !== 64'h1234) begin n_err++; $display("FAIL load_a_pc got %h exp 1234", a_pc_out); end
        @(posedge clk); #1;
        n_cmp++; if (a_stall !== 16'd1) begin n_err++; $display("FAIL pre_rst_stall got %0d exp 1", a_stall); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL async_valid got %b exp 0", a_out_valid); end
        n_cmp++; if (a_pc_out !== 64'h0) begin n_err++; $display("FAIL async_pc got %h exp 0", a_pc_out); end
        n_cmp++; if (a_bus_out !== 64'h0) begin n_err++; $display("FAIL async_bus got %h exp 0", a_bus_out); end
        n_cmp++; if (a_stall !== 16'd0) begin n_err++; $display("FAIL async_stall got %0d exp 0", a_stall); end
        n_cmp++; if (a_in_allowin !== 1'b1) begin n_err++; $display("FAIL async_allowin got %b exp 1", a_in_allowin); end
        @(posedge clk); #1;
        rst = 1'b0;
        a_out_allowin = 1'b1;
    endtask

    task automatic test_stream_single;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL strA_valid[%0d] got %b exp 1", i, a_out_valid); end
                n_cmp++; if (a_pc_out !== 64'(i)) begin n_err++; $display("FAIL strA_pc[%0d] got %h exp %h", i, a_pc_out, i); end
                n_cmp++; if (a_bus_out !== 64'(i * 16)) begin n_err++; $display("FAIL strA_bus[%0d] got %h exp %h", i, a_bus_out, i * 16); end
                n_cmp++; if (a_stall !== 16'd0) begin n_err++; $display("FAIL strA_stall got %0d exp 0", a_stall); end
            end
            if (i < 8) begin
                a_in_valid = 1'b1; a_pc_in = 64'(i + 1); a_bus_in = 64'((i + 1) * 16);
                n_cmp++; if (a_in_allowin !== 1'b1) begin n_err++; $display("FAIL strA_allowin got %b exp 1", a_in_allowin); end
            end else begin
                a_in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL strA_drain got %b exp 0", a_out_valid); end
    endtask

    task automatic test_stream_skid;
        for (int i = 0; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                n_cmp++; if (b_out_valid !== 1'b1) begin n_err++; $display("FAIL strB_valid[%0d] got %b exp 1", i, b_out_valid); end
                n_cmp++; if (b_pc_out !== 64'(i)) begin n_err++; $display("FAIL strB_pc[%0d] got %h exp %h", i, b_pc_out, i); end
                n_cmp++; if (b_stall !== 3'd0) begin n_err++; $display("FAIL strB_stall got %0d exp 0", b_stall); end
                n_cmp++; if (b_in_allowin !== 1'b1) begin n_err++; $display("FAIL strB_allowin got %b exp 1", b_in_allowin); end
            end
            if (i < 8) begin
                b_in_valid = 1'b1; b_pc_in = 64'(i + 1); b_bus_in = 64'(i + 1);
            end else begin
                b_in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL strB_drain got %b exp 0", b_out_valid); end
    endtask

    task automatic test_backpressure;
        b_out_allowin = 1'b0; b_in_valid = 1'b1; b_pc_in = 64'hA; b_bus_in = 64'hA0;
        @(posedge clk); #1;
        n_cmp++; if (b_pc_out !== 64'hA) begin n_err++; $display("FAIL bp_head0 got %h exp a", b_pc_out); end
        n_cmp++; if (b_in_allowin !== 1'b1) begin n_err++; $display("FAIL bp_allow0 got %b exp 1", b_in_allowin); end
        b_pc_in = 64'hB; b_bus_in = 64'hB0;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n_cmp++; if (b_pc_out !== 64'hA) begin n_err++; $display("FAIL bp_head1 got %h exp a", b_pc_out); end
        n_cmp++; if (b_in_allowin !== 1'b0) begin n_err++; $display("FAIL bp_full got %b exp 0", b_in_allowin); end
        b_out_allowin = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (b_pc_out !== 64'hB) begin n_err++; $display("FAIL bp_head2 got %h exp b", b_pc_out); end
        n_cmp++; if (b_bus_out !== 64'hB0) begin n_err++; $display("FAIL bp_bus2 got %h exp b0", b_bus_out); end
        n_cmp++; if (b_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid2 got %b exp 1", b_out_valid); end
        n_cmp++; if (b_in_allowin !== 1'b1) begin n_err++; $display("FAIL bp_reopen got %b exp 1", b_in_allowin); end
        @(posedge clk); #1;
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_nodup got %b exp 0", b_out_valid); end
        n_cmp++; if (b_stall !== 3'd1) begin n_err++; $display("FAIL bp_stall got %0d exp 1", b_stall); end
    endtask

    task automatic test_flush;
        // Skid config: head and skid both full, flush with an offered input.
        b_out_allowin = 1'b0; b_in_valid = 1'b1; b_pc_in = 64'h1;
        @(posedge clk); #1;
        b_pc_in = 64'h2;
        @(posedge clk); #1;
        b_flush = 1'b1; b_pc_in = 64'hC;
        @(posedge clk); #1;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_allowin = 1'b1;
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL flB_valid got %b exp 0", b_out_valid); end
        n_cmp++; if (b_in_allowin !== 1'b1) begin n_err++; $display("FAIL flB_allowin got %b exp 1", b_in_allowin); end
        n_cmp++; if (b_pc_out !== 64'h1) begin n_err++; $display("FAIL flB_hold got %h exp 1", b_pc_out); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL flB_ghost got %b exp 0", b_out_valid); end
        end
        // Single config: input would be accepted, but flush drops it.
        a_out_allowin = 1'b1; a_in_valid = 1'b1; a_pc_in = 64'h11;
        @(posedge clk); #1;
        a_flush = 1'b1; a_pc_in = 64'hC;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flA_valid got %b exp 0", a_out_valid); end
        n_cmp++; if (a_pc_out !== 64'h11) begin n_err++; $display("FAIL flA_hold got %h exp 11", a_pc_out); end
    endtask

    task automatic test_stall_sat;
        @(posedge clk); #1;
        rst = 1'b1;
        #2 rst = 1'b0;
        b_out_allowin = 1'b0; b_in_valid = 1'b1; b_pc_in = 64'h5;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        n_cmp++; if (b_stall !== 3'd0) begin n_err++; $display("FAIL stall_start got %0d exp 0", b_stall); end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (b_stall !== 3'((k > 7) ? 7 : k)) begin n_err++; $display("FAIL stall[%0d] got %0d exp %0d", k, b_stall, (k > 7) ? 7 : k); end
        end
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        n_cmp++; if (b_stall !== 3'd7) begin n_err++; $display("FAIL stall_flush got %0d exp 7", b_stall); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_flush_valid got %b exp 0", b_out_valid); end
        b_out_allowin = 1'b1;
    endtask

    task automatic test_width;
        logic [96:0] sb[$];
        logic [96:0] exp_e;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            c_in_valid    = (k < 280) ? 1'($urandom_range(0, 1)) : 1'b0;
            c_out_allowin = (k < 280) ? 1'($urandom_range(0, 1)) : 1'b1;
            c_pc_in       = {$urandom, $urandom, $urandom};
            c_bus_in      = 1'($urandom_range(0, 1));
            if (c_out_valid && c_out_allowin) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL width_extra got pc %h exp none", c_pc_out);
                end else begin
                    exp_e = sb.pop_front();
                    if ({c_bus_out, c_pc_out} !== exp_e) begin
                        n_err++; $display("FAIL width_data got %h exp %h", {c_bus_out, c_pc_out}, exp_e);
                    end
                end
            end
            if (c_in_valid && c_in_allowin) sb.push_back({c_bus_in, c_pc_in});
        end
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL width_lost got %0d exp 0", sb.size()); end
        n_cmp++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL width_tail got %b exp 0", c_out_valid); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_out_allowin = 1; a_pc_in = '0; a_bus_in = '0;
        b_flush = 0; b_in_valid = 0; b_out_allowin = 1; b_pc_in = '0; b_bus_in = '0;
        c_flush = 0; c_in_valid = 0; c_out_allowin = 1; c_pc_in = '0; c_bus_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_stream_single;
        test_stream_skid;
        test_backpressure;
        test_flush;
        test_stall_sat;
        test_width;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
